// File: rtl/ms_wdog_pkg.sv
// ms_wdog shared definitions: FSM state encoding and status-word
// bit positions used by the watchdog and its register view.
package ms_wdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam int EN_BIT  = 31;
    localparam int EXP_BIT = 30;
    localparam int FC_HI   = 29;
    localparam int FC_LO   = 22;

endpackage

// File: rtl/ms_wdog.sv
// ms_wdog: millisecond watchdog. A write of {enable, timeout} arms the
// counter, each ms_tick decrements it while running, and running out
// raises a registered one-cycle trig pulse plus a level expired flag.
// Ports: clk, rst (sync, active-high), ms_tick, wr, data_in[31:0],
//        data_out[31:0] (status), trig, expired.
// Option: MS_WDOG_FIRECNT_EN adds a saturating 8-bit fire counter in
//         data_out[29:22], cleared only by rst (needs CNT_W <= 22).
module ms_wdog
    import ms_wdog_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_tick,
    input  logic        wr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        trig,
    output logic        expired
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               trig_q, trig_d;
    logic               run_tick;

    // Timeout bits above the counter width and below bit 31 are don't-care.
    logic unused_data_in;
    assign unused_data_in = ^data_in[30:CNT_W];

    assign run_tick = ms_tick && (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            trig_q  <= trig_d;
        end
    end

    // A write always takes precedence over a coincident tick, so a kick
    // in the same cycle as the final tick never produces trig.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        trig_d  = 1'b0;
        priority case (1'b1)
            wr && data_in[EN_BIT]: begin
                state_d = RUN;
                count_d = data_in[CNT_W-1:0];
            end
            wr: begin
                state_d = IDLE;
                count_d = '0;
            end
            run_tick && (count_q > CNT_W'(1)): begin
                count_d = count_q - CNT_W'(1);
            end
            run_tick: begin
                count_d = '0;
                state_d = EXPIRED;
                trig_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign trig    = trig_q;
    assign expired = (state_q == EXPIRED);

`ifdef MS_WDOG_FIRECNT_EN
    logic [7:0] fire_q;

    // trig_d is high exactly on the RUN -> EXPIRED transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q <= '0;
        end else if (trig_d && (fire_q != 8'hFF)) begin
            fire_q <= fire_q + 8'd1;
        end
    end
`endif

    always_comb begin
        data_out              = '0;
        data_out[CNT_W-1:0]   = count_q;
`ifdef MS_WDOG_FIRECNT_EN
        data_out[FC_HI:FC_LO] = fire_q;
`endif
        data_out[EN_BIT]      = (state_q == RUN);
        data_out[EXP_BIT]     = expired;
    end

endmodule

// File: doc/ms_wdog.md
# ms_wdog

Millisecond watchdog/countdown that consumes the `ms_tick` strobe of the system millisecond timer. The CPU loads a timeout in milliseconds via a single I/O register. The block decrements it once per tick and raises a one-cycle `trig` pulse plus a level `expired` flag when the count runs out. It sits beside the millisecond timer on the I/O bus; `trig` feeds the reset/abort logic.

## Interface
Parameters:
- `CNT_W`, 16: width of the timeout counter in bits; legal range 8..24.

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `ms_tick` input 1: one-cycle strobe, once per millisecond, from the millisecond timer.
- `wr` input 1: register write strobe, one cycle.
- `data_in` input 32: write data.
  - bit 31 = enable.
  - bits [CNT_W-1:0] = timeout.
  - all other bits ignored.
- `data_out` output 32: status word, combinational from registers.
  - bit 31 = enabled.
  - bit 30 = expired.
  - bits [CNT_W-1:0] = current count.
  - all other bits 0.
- `trig` output 1: one-cycle pulse on expiry.
- `expired` output 1: level; high in EXPIRED state.

## Operation
- States: IDLE, RUN, EXPIRED.
- Reset:
  - state = IDLE, count = 0, `trig` = 0, `expired` = 0.
  - `data_out` = 0.
- Write with bit 31 = 1 (any state):
  - count <= timeout.
  - state <= RUN.
  - `expired` cleared.
  - This is also the "kick".
- Write with bit 31 = 0 (any state):
  - state <= IDLE.
  - count <= 0.
  - `expired` cleared.
- RUN, `ms_tick` with count > 1: count <= count - 1.
- RUN, `ms_tick` with count <= 1:
  - count <= 0.
  - state <= EXPIRED.
  - `trig` = 1 for the next cycle only.
- Timeout = 0 or 1: expires on the first `ms_tick` after the write.
- IDLE and EXPIRED: `ms_tick` is ignored; count holds.
- EXPIRED: exited only by a write or by `rst`.
- Counter never wraps; decrement below 0 is impossible.
- Simultaneous `wr` and `ms_tick` in the same cycle:
  - The write wins; the tick is discarded.
  - No `trig` is generated in that cycle, even if RUN with count = 1.
- `rst` together with `wr` or `ms_tick`: `rst` wins.

## Timing
- `wr` sampled at edge N: new state and count visible on `data_out` after edge N.
- Expiring `ms_tick` sampled at edge N:
  - `trig` = 1 and `expired` = 1 during cycle N+1.
  - `trig` returns to 0 at edge N+1; `expired` stays high.
- A timeout of T loaded between ticks expires on the T-th following tick. Real delay is therefore between T-1 and T ms.
- `trig` is registered; never combinational from inputs.
- `ms_tick` must not be asserted on consecutive cycles. Behaviour is still defined if it is: one decrement per asserted cycle.

## Configuration
- Macro: `MS_WDOG_FIRECNT_EN`.
- Defined:
  - An 8-bit saturating fire counter increments on every transition into EXPIRED.
  - It is readable in `data_out[29:22]`.
  - It is cleared only by `rst`, not by writes.
  - `CNT_W` must be <= 22 when defined.
- Undefined: no counter exists; `data_out[29:22]` = 0.

## Structure
- Shared package `ms_wdog_pkg` holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2).
  - Bit-position constants for enable (31), expired (30) and fire count (29:22).
- Single module; no sub-module needed. The down-counter stays inline, as it is trivially small.

## Test plan
- Reset → `data_out` = 0, `trig` = 0, `expired` = 0. 50 ticks applied in IDLE → count stays 0.
- Write 0x8000_0003, then 3 ticks 10 cycles apart → count reads 2, 1.
  - `trig` pulses exactly once, one cycle after the 3rd tick.
  - `data_out` = 0x4000_0000 afterwards.
- Write 0x8000_0005, 3 ticks, write 0x8000_0005 again (kick), 4 ticks → no `trig`, count = 1. One more tick → `trig`.
- RUN with count = 1, `wr` = 0x8000_0004 and `ms_tick` in the same cycle → no `trig`, count = 4, state RUN.
- Write 0x8000_0000 → `trig` on the first tick. Write 0x0000_0009 while RUN → IDLE, count 0, `expired` = 0, no `trig` on later ticks.
- With `MS_WDOG_FIRECNT_EN`, 300 expiries → `data_out[29:22]` = 255 (saturated). A write leaves it unchanged; `rst` clears it to 0.
